// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES word packer and its block FIFO.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_KEY  = 1'b1
  } aes_pack_state_e;

  localparam int AES_WORDS_PER_BLOCK = 4;

  // Slot 0 is the most significant word (FIPS-197 byte order).
  function automatic aes_block_t aes_place_word(input aes_block_t base,
                                                input aes_word_t  w,
                                                input logic [1:0] slot);
    aes_block_t r;
    r = base;
    case (slot)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO; head entry is read straight from the storage flops.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  aes_block_t push_data_i,
  input  logic       pop_i,
  output aes_block_t data_o,
  output logic       valid_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  aes_block_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = !empty_o;
  assign data_o  = mem_q[rd_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/aes_word_packer.sv
// Packs 32-bit words into 128-bit data blocks (FIFO) or key loads.
// Define AES_PACK_PAD_EN to zero-pad short data groups ended by word_last_i.
module aes_word_packer
  import aes_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            word_valid_i,
  output logic            word_ready_o,
  input  aes_word_t       word_i,
  input  logic            word_is_key_i,
  input  logic            word_last_i,
  output logic            blk_valid_o,
  input  logic            blk_ready_i,
  output aes_block_t      blk_o,
  output aes_block_t      key_o,
  output logic            load_key_o,
  output logic            err_o,
  input  logic            clear_err_i,
  output logic [CNT_W-1:0] blk_count_o,
  output aes_pack_state_e dbg_state_o,
  output logic [1:0]      dbg_idx_o
);

  localparam logic [1:0] LAST_IDX = 2'(AES_WORDS_PER_BLOCK - 1);

  aes_pack_state_e  state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  aes_block_t       asm_q, asm_d;
  aes_block_t       key_q, key_d;
  logic             load_key_q, load_key_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  logic       fifo_full, fifo_empty, fifo_valid;
  logic       push, pop, xfer, mismatch, ready_raw, err_set;
  logic [1:0] eff_idx;
  aes_block_t asm_word;

  // A word of the other type restarts the group at slot 0.
  assign mismatch = (idx_q != 2'd0) && (word_is_key_i != (state_q == ST_KEY));
  assign eff_idx  = mismatch ? 2'd0 : idx_q;
  assign asm_word = aes_place_word((eff_idx == 2'd0) ? '0 : asm_q, word_i, eff_idx);

  always_comb begin
    if (word_is_key_i) ready_raw = (eff_idx == LAST_IDX) ? (fifo_empty && !fifo_valid) : 1'b1;
    else               ready_raw = !fifo_full;
  end

  assign word_ready_o = rst_ni && ready_raw;
  assign xfer         = word_valid_i && word_ready_o;
  assign pop          = fifo_valid && blk_ready_i;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    key_d      = key_q;
    load_key_d = 1'b0;
    push       = 1'b0;
    err_set    = 1'b0;
    if (xfer) begin
      state_d = word_is_key_i ? ST_KEY : ST_DATA;
      asm_d   = asm_word;
      err_set = mismatch;
      if (eff_idx == LAST_IDX) begin
        idx_d = 2'd0;
        if (word_is_key_i) begin
          key_d      = asm_word;
          load_key_d = 1'b1;
        end else begin
          push = 1'b1;
        end
      end else if (!word_is_key_i && word_last_i) begin
        idx_d = 2'd0;
`ifdef AES_PACK_PAD_EN
        push = 1'b1;
`else
        err_set = 1'b1;
`endif
      end else begin
        idx_d = eff_idx + 2'd1;
      end
    end
    if (err_set)          err_d = 1'b1;
    else if (clear_err_i) err_d = 1'b0;
    else                  err_d = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_DATA;
      idx_q      <= 2'd0;
      asm_q      <= '0;
      key_q      <= '0;
      load_key_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      key_q      <= key_d;
      load_key_q <= load_key_d;
      err_q      <= err_d;
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  aes_blk_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (asm_word),
    .pop_i       (pop),
    .data_o      (blk_o),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign blk_valid_o = fifo_valid;
  assign key_o       = key_q;
  assign load_key_o  = load_key_q;
  assign err_o       = err_q;
  assign blk_count_o = cnt_q;
  assign dbg_state_o = state_q;
  assign dbg_idx_o   = idx_q;

endmodule

// File: tb/tb_aes_word_packer.sv
// Scoreboard bench for aes_word_packer: queue-based group model, decoupled monitor.
module tb_aes_word_packer;
  import aes_pkg::*;

  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             word_valid_i = 1'b0;
  logic             word_ready_o;
  logic [31:0]      word_i = '0;
  logic             word_is_key_i = 1'b0;
  logic             word_last_i = 1'b0;
  logic             blk_valid_o;
  logic             blk_ready_i;
  logic [127:0]     blk_o;
  logic [127:0]     key_o;
  logic             load_key_o;
  logic             err_o;
  logic             clear_err_i = 1'b0;
  logic [CNT_W-1:0] blk_count_o;
  aes_pack_state_e  dbg_state;
  logic [1:0]       dbg_idx;

  aes_word_packer #(.OUT_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .word_i        (word_i),
    .word_is_key_i (word_is_key_i),
    .word_last_i   (word_last_i),
    .blk_valid_o   (blk_valid_o),
    .blk_ready_i   (blk_ready_i),
    .blk_o         (blk_o),
    .key_o         (key_o),
    .load_key_o    (load_key_o),
    .err_o         (err_o),
    .clear_err_i   (clear_err_i),
    .blk_count_o   (blk_count_o),
    .dbg_state_o   (dbg_state),
    .dbg_idx_o     (dbg_idx)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] key_exp_q[$];
  logic [31:0]  grp_q[$];
  logic         grp_key = 1'b0;
  logic         model_err = 1'b0;
  logic [CNT_W-1:0] pop_cnt = '0;
  int           key_pulses = 0;
  int           rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_group();
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < grp_q.size(); i++) b[127-32*i -: 32] = grp_q[i];
    return b;
  endfunction

  // Reference model: one accepted word at a time, groups held as a word list.
  task automatic model_accept(input logic [31:0] w, input logic k, input logic l);
    if (grp_q.size() != 0 && k != grp_key) begin
      model_err = 1'b1;
      grp_q.delete();
    end
    grp_key = k;
    grp_q.push_back(w);
    if (grp_q.size() == 4) begin
      if (k) key_exp_q.push_back(pack_group());
      else   exp_q.push_back(pack_group());
      grp_q.delete();
    end else if (!k && l) begin
`ifdef AES_PACK_PAD_EN
      exp_q.push_back(pack_group());
`else
      model_err = 1'b1;
`endif
      grp_q.delete();
    end
  endtask

  task automatic send(input logic [31:0] w, input logic k, input logic l);
    int n;
    n = 0;
    word_i = w; word_is_key_i = k; word_last_i = l; word_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (word_ready_o) break;
      n++;
      if (n > 300) break;
    end
    if (n > 300) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=stalled required=accept word=%h", w);
      word_valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
      model_accept(w, k, l);
      #1;
      word_valid_i = 1'b0;
      chk("err_track", 128'(err_o), 128'(model_err));
    end
  endtask

  task automatic present(input logic [31:0] w, input logic k, input logic l);
    word_i = w; word_is_key_i = k; word_last_i = l; word_valid_i = 1'b1;
  endtask

  task automatic clear_err();
    clear_err_i = 1'b1;
    @(posedge clk_i); #1;
    clear_err_i = 1'b0;
    model_err = 1'b0;
    chk("err_clear", 128'(err_o), 128'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || key_exp_q.size() != 0 || blk_valid_o) && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("drain", 128'(exp_q.size() + key_exp_q.size()), 128'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 128'(word_ready_o), 128'(0));
    chk({tag, "_valid"}, 128'(blk_valid_o), 128'(0));
    chk({tag, "_blk"}, blk_o, 128'(0));
    chk({tag, "_key"}, key_o, 128'(0));
    chk({tag, "_load"}, 128'(load_key_o), 128'(0));
    chk({tag, "_err"}, 128'(err_o), 128'(0));
    chk({tag, "_count"}, 128'(blk_count_o), 128'(0));
  endtask

  initial begin
    blk_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (rdy_mode)
        0:       blk_ready_i = 1'b0;
        1:       blk_ready_i = 1'b1;
        default: blk_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every popped block and every key pulse against the queues.
  initial begin
    logic [127:0] prev;
    logic         stalled;
    prev = '0;
    stalled = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stalled = 1'b0;
      end else begin
        if (stalled && blk_valid_o) chk("blk_stable", blk_o, prev);
        if (blk_valid_o && blk_ready_i) begin
          chk("blk_count", 128'(blk_count_o), 128'(pop_cnt));
          pop_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL blk_unexpected actual=%h required=none", blk_o);
          end else begin
            chk("blk_data", blk_o, exp_q.pop_front());
          end
        end
        stalled = blk_valid_o && !blk_ready_i;
        prev = blk_o;
        if (load_key_o) begin
          key_pulses++;
          if (key_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL key_unexpected actual=%h required=none", key_o);
          end else begin
            chk("key_data", key_o, key_exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int kp;
    logic [31:0] w;
    logic k, l;

    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_vals("rst");
    #2 rst_ni = 1'b1;
    #1 chk("ready_after_reset", 128'(word_ready_o), 128'(1));

    // Basic data block
    rdy_mode = 1;
    repeat (2) @(posedge clk_i);
    #1;
    send(32'h00112233, 1'b0, 1'b0);
    send(32'h44556677, 1'b0, 1'b0);
    send(32'h8899AABB, 1'b0, 1'b0);
    send(32'hCCDDEEFF, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("data_latency", 128'(blk_valid_o), 128'(1));
    chk("data_value", blk_o, 128'h00112233445566778899AABBCCDDEEFF);
    drain();
    chk("count_one", 128'(blk_count_o), 128'(1));

    // Backpressure: two blocks buffered, ninth word stalls
    rdy_mode = 0;
    repeat (2) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) send(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    present(32'hA000_0008, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_ready_low", 128'(word_ready_o), 128'(0));
    end
    chk("bp_valid", 128'(blk_valid_o), 128'(1));
    rdy_mode = 1;
    for (int i = 8; i < 12; i++) send(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    drain();
    chk("bp_count", 128'(blk_count_o), 128'(4));

    // Key gating behind a pending data block
    rdy_mode = 0;
    repeat (2) @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) send(32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    send(32'h2B7E1516, 1'b1, 1'b0);
    send(32'h28AED2A6, 1'b1, 1'b0);
    send(32'hABF71588, 1'b1, 1'b0);
    present(32'h09CF4F3C, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk_i);
      chk("key_stall", 128'(word_ready_o), 128'(0));
    end
    kp = key_pulses;
    rdy_mode = 1;
    send(32'h09CF4F3C, 1'b1, 1'b0);
    chk("key_pulse_now", 128'(load_key_o), 128'(1));
    chk("key_value", key_o, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
    @(posedge clk_i); #1;
    chk("key_pulse_gone", 128'(load_key_o), 128'(0));
    drain();
    chk("key_pulse_count", 128'(key_pulses - kp), 128'(1));

    // Group type mismatch
    send(32'hC0000000, 1'b0, 1'b0);
    send(32'hC0000001, 1'b0, 1'b0);
    send(32'h11111111, 1'b1, 1'b0);
    chk("mm_err", 128'(err_o), 128'(1));
    send(32'h22222222, 1'b1, 1'b0);
    send(32'h33333333, 1'b1, 1'b0);
    send(32'h44444444, 1'b1, 1'b0);
    drain();
    chk("mm_key", key_o, 128'h11111111222222223333333344444444);
    clear_err();

    // Partial group terminated by word_last_i
    send(32'hDEADBEEF, 1'b0, 1'b1);
    @(negedge clk_i);
`ifdef AES_PACK_PAD_EN
    chk("partial_err", 128'(err_o), 128'(0));
    chk("partial_valid", 128'(blk_valid_o), 128'(1));
    chk("partial_blk", blk_o, {32'hDEADBEEF, 96'h0});
`else
    chk("partial_err", 128'(err_o), 128'(1));
    chk("partial_valid", 128'(blk_valid_o), 128'(0));
`endif
    drain();
    clear_err();

    // Reset in the middle of a group
    send(32'hE0000000, 1'b0, 1'b0);
    send(32'hE0000001, 1'b0, 1'b0);
    send(32'hE0000002, 1'b0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset_vals("midrst");
    grp_q.delete();
    exp_q.delete();
    key_exp_q.delete();
    model_err = 1'b0;
    pop_cnt = '0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) send(32'hF0000000 + 32'(i), 1'b0, 1'b0);
    drain();
    repeat (2) @(posedge clk_i);
    #1 chk("post_reset_count", 128'(blk_count_o), 128'(1));

    // Randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      k = ($urandom_range(0, 4) == 0);
      l = ($urandom_range(0, 9) == 0);
      send(w, k, l);
      if ($urandom_range(0, 19) == 0) clear_err();
    end
    rdy_mode = 1;
    drain();
    repeat (2) @(posedge clk_i);
    #1 chk("final_count", 128'(blk_count_o), 128'(pop_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
